// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative write-back cache: FSM encoding
// and address-field width helpers.
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      WB_WAIT,
      FILL,
      FILL_WAIT
   } state_t;

   function automatic int off_w(input int line_size);
      return $clog2(line_size);
   endfunction

   function automatic int idx_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_w(input int line_size, input int num_sets);
      return 32 - off_w(line_size) - idx_w(num_sets);
   endfunction

   // A direct-mapped cache still carries a 1-bit way index that is always 0.
   function automatic int way_w(input int num_ways);
      return (num_ways > 1) ? $clog2(num_ways) : 1;
   endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set true-LRU age tracking; the oldest way (highest age) is the victim.
// Degenerates to a constant way 0 when NUM_WAYS == 1.
module cache_lru
   import cache_pkg::*;
#(
   parameter int NUM_SETS = 16,
   parameter int NUM_WAYS = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [idx_w(NUM_SETS)-1:0]  set,
   input  logic [way_w(NUM_WAYS)-1:0]  way,
   input  logic                        update,
   output logic [way_w(NUM_WAYS)-1:0]  victim
);

   localparam int WAY_W = way_w(NUM_WAYS);

   generate
      if (NUM_WAYS == 1) begin : g_dm
         logic w_unused_ok;
         assign w_unused_ok = ^{clk, reset, set, way, update};
         assign victim      = '0;
      end else begin : g_lru
         localparam int AGE_W = $clog2(NUM_WAYS);
         localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_WAYS - 1);

         logic [AGE_W-1:0] r_age [NUM_SETS][NUM_WAYS];
         logic [AGE_W-1:0] w_acc_age;
         logic [AGE_W-1:0] w_max_age;
         logic [WAY_W-1:0] w_victim;

         assign w_acc_age = r_age[set][way];

         // Ways tied with the accessed one also age, so the all-zero reset
         // state settles into a strict ordering as ways are first touched.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < NUM_SETS; s++)
                  for (int w = 0; w < NUM_WAYS; w++)
                     r_age[s][w] <= '0;
            end else if (update) begin
               for (int w = 0; w < NUM_WAYS; w++) begin
                  if (WAY_W'(w) == way)
                     r_age[set][w] <= '0;
                  else if (r_age[set][w] <= w_acc_age && r_age[set][w] != AGE_MAX)
                     r_age[set][w] <= r_age[set][w] + 1'b1;
               end
            end
         end

         always_comb begin
            w_max_age = r_age[set][0];
            w_victim  = '0;
            for (int w = 1; w < NUM_WAYS; w++) begin
               if (r_age[set][w] > w_max_age) begin
                  w_max_age = r_age[set][w];
                  w_victim  = WAY_W'(w);
               end
            end
         end

         assign victim = w_victim;
      end
   endgenerate

endmodule

// File: rtl/assoc_wb_cache.sv
// Set-associative write-back / write-allocate cache with a line-wide memory port.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module assoc_wb_cache
   import cache_pkg::*;
#(
   parameter int LINE_SIZE = 16,
   parameter int NUM_SETS  = 16,
   parameter int NUM_WAYS  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   is_input_valid,
   input  logic [31:0]            addr,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            din,
   output logic                   is_ready,
   output logic                   is_output_valid,
   output logic [31:0]            dout,
   output logic                   is_hit,
   output logic                   mem_req_valid,
   output logic                   mem_req_write,
   output logic [31:0]            mem_req_addr,
   output logic [LINE_SIZE*8-1:0] mem_req_wdata,
   input  logic                   mem_ready,
   input  logic                   mem_resp_valid,
   input  logic [LINE_SIZE*8-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]            hit_count,
   output logic [31:0]            miss_count
`endif
);

   localparam int OFF_W  = off_w(LINE_SIZE);
   localparam int IDX_W  = idx_w(NUM_SETS);
   localparam int TAG_W  = tag_w(LINE_SIZE, NUM_SETS);
   localparam int WAY_W  = way_w(NUM_WAYS);
   localparam int LINE_W = LINE_SIZE * 8;

   state_t              r_state;
   logic [31:0]         r_addr;
   logic                r_write;
   logic [31:0]         r_din;
   logic                r_missed;
   logic [WAY_W-1:0]    r_victim;
   logic                r_mem_req_valid;
   logic                r_mem_req_write;
   logic [31:0]         r_mem_req_addr;
   logic [LINE_W-1:0]   r_mem_req_wdata;

   logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
   logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
   logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
   logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];

   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [31:0]         w_word;
   logic                w_hit;
   logic [WAY_W-1:0]    w_hit_way;
   logic                w_inv_found;
   logic [WAY_W-1:0]    w_inv_way;
   logic [WAY_W-1:0]    w_lru_victim;
   logic [WAY_W-1:0]    w_victim;
   logic [LINE_W-1:0]   w_hit_line;
   logic [31:0]         w_rd_word;
   logic                w_done;
   logic                w_fill_done;
   logic                w_lru_upd;
   logic [WAY_W-1:0]    w_lru_way;

   assign w_idx  = r_addr[OFF_W +: IDX_W];
   assign w_tag  = r_addr[31 -: TAG_W];
   assign w_word = 32'(r_addr[OFF_W-1:0]) >> 2;

   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag && !w_hit) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!r_valid[w_idx][w] && !w_inv_found) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
      end
   end

   assign w_victim    = w_inv_found ? w_inv_way : w_lru_victim;
   assign w_hit_line  = r_data[w_idx][w_hit_way];
   assign w_rd_word   = w_hit_line[w_word*32 +: 32];
   assign w_done      = (r_state == LOOKUP) && w_hit;
   assign w_fill_done = (r_state == FILL_WAIT) && mem_resp_valid;
   assign w_lru_upd   = w_done || w_fill_done;
   assign w_lru_way   = (r_state == FILL_WAIT) ? r_victim : w_hit_way;

   cache_lru #(
      .NUM_SETS (NUM_SETS),
      .NUM_WAYS (NUM_WAYS)
   ) u_lru (
      .clk    (clk),
      .reset  (reset),
      .set    (w_idx),
      .way    (w_lru_way),
      .update (w_lru_upd),
      .victim (w_lru_victim)
   );

   // Completion is decided in the LOOKUP cycle itself, so these are combinational
   // off registered state to keep hit latency at one cycle.
   assign is_ready        = (r_state == IDLE);
   assign is_output_valid = w_done;
   assign dout            = w_done ? w_rd_word : 32'd0;
   assign is_hit          = w_done && !r_missed;
   assign mem_req_valid   = r_mem_req_valid;
   assign mem_req_write   = r_mem_req_write;
   assign mem_req_addr    = r_mem_req_addr;
   assign mem_req_wdata   = r_mem_req_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_addr          <= '0;
         r_write         <= 1'b0;
         r_din           <= '0;
         r_missed        <= 1'b0;
         r_victim        <= '0;
         r_mem_req_valid <= 1'b0;
         r_mem_req_write <= 1'b0;
         r_mem_req_addr  <= '0;
         r_mem_req_wdata <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (is_input_valid) begin
                  r_addr   <= addr;
                  r_write  <= mem_write & ~mem_read;
                  r_din    <= din;
                  r_missed <= 1'b0;
                  r_state  <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (w_hit) begin
                  if (r_write) begin
                     r_data[w_idx][w_hit_way][w_word*32 +: 32] <= r_din;
                     r_dirty[w_idx][w_hit_way]                 <= 1'b1;
                  end
                  r_state <= IDLE;
               end else begin
                  r_missed        <= 1'b1;
                  r_victim        <= w_victim;
                  r_mem_req_valid <= 1'b1;
                  if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                     r_mem_req_write <= 1'b1;
                     r_mem_req_addr  <= 32'({r_tag[w_idx][w_victim], w_idx});
                     r_mem_req_wdata <= r_data[w_idx][w_victim];
                     r_state         <= WRITEBACK;
                  end else begin
                     r_mem_req_write <= 1'b0;
                     r_mem_req_addr  <= 32'({w_tag, w_idx});
                     r_state         <= FILL;
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= WB_WAIT;
               end
            end
            WB_WAIT: begin
               if (mem_resp_valid) begin
                  r_mem_req_valid <= 1'b1;
                  r_mem_req_write <= 1'b0;
                  r_mem_req_addr  <= 32'({w_tag, w_idx});
                  r_state         <= FILL;
               end
            end
            FILL: begin
               if (mem_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= FILL_WAIT;
               end
            end
            FILL_WAIT: begin
               if (mem_resp_valid) begin
                  r_data[w_idx][r_victim]  <= mem_resp_rdata;
                  r_tag[w_idx][r_victim]   <= w_tag;
                  r_valid[w_idx][r_victim] <= 1'b1;
                  r_dirty[w_idx][r_victim] <= 1'b0;
                  r_state                  <= LOOKUP;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (w_done) begin
         if (r_missed) r_miss_count <= r_miss_count + 32'd1;
         else          r_hit_count  <= r_hit_count + 32'd1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Randomized bench for assoc_wb_cache against a recency-list reference model.
module tb_assoc_wb_cache;

  localparam int SETS = 16;
  localparam int WAYS = 2;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [127:0] data;
  } mreq_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  din = '0;
  logic         is_ready, is_output_valid, is_hit;
  logic [31:0]  dout;
  logic         mem_req_valid, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  assoc_wb_cache dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din), .is_ready(is_ready),
    .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Backing memory: written only by the responder; untouched lines follow a pattern.
  logic [127:0] mem [logic [31:0]];
  mreq_t        req_log[$];
  bit           stall_mode = 0;
  bit           stale_go = 0;
  bit           stalled = 0;

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    if (mem.exists(la)) return mem[la];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = {la[23:0], 8'(i)} ^ 32'h5A00_0000;
    return l;
  endfunction

  initial begin
    mreq_t r;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !reset) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        r.wr = mem_req_write; r.addr = mem_req_addr; r.data = mem_req_wdata;
        req_log.push_back(r);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        if (stall_mode) begin
          stalled = 1;
          wait (stale_go);
          @(negedge clk);
          mem_resp_rdata = '1;
          mem_resp_valid = 1'b1;
          @(negedge clk);
          mem_resp_valid = 1'b0;
          stalled = 0;
        end else begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if (r.wr) mem[r.addr] = r.data;
          mem_resp_rdata = r.wr ? '0 : mem_line(r.addr);
          mem_resp_valid = 1'b1;
          @(negedge clk);
          mem_resp_valid = 1'b0;
        end
      end
    end
  end

  // Reference model: per-set recency list of resident lines (front = most recent).
  logic [31:0]  lru_q [SETS][$];
  logic [127:0] cdata [logic [31:0]];
  bit           cdirty [logic [31:0]];
  mreq_t        exp_q[$];
  bit           exp_hit;
  logic [31:0]  exp_dout;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) lru_q[s].delete();
    cdata.delete();
    cdirty.delete();
  endtask

  task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] d);
    logic [31:0]  la, v;
    logic [127:0] line;
    int s, wsel, pos;
    mreq_t r;
    la = a >> 4;
    s = int'(la % SETS);
    wsel = int'((a >> 2) & 32'd3);
    exp_q.delete();
    pos = -1;
    for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == la) pos = i;
    exp_hit = (pos >= 0);
    if (exp_hit) lru_q[s].delete(pos);
    else begin
      if (lru_q[s].size() == WAYS) begin
        v = lru_q[s].pop_back();
        if (cdirty[v]) begin r.wr = 1; r.addr = v; r.data = cdata[v]; exp_q.push_back(r); end
        cdata.delete(v);
        cdirty.delete(v);
      end
      r.wr = 0; r.addr = la; r.data = '0; exp_q.push_back(r);
      cdata[la] = mem_line(la);
      cdirty[la] = 0;
    end
    lru_q[s].push_front(la);
    line = cdata[la];
    exp_dout = line[wsel*32 +: 32];
    if (wr) begin
      line[wsel*32 +: 32] = d;
      cdata[la] = line;
      cdirty[la] = 1;
    end
  endtask

  logic [31:0] last_dout;
  logic        last_hit;
  int          last_base;

  task automatic do_req(input logic [31:0] a, input bit wr, input logic [31:0] d);
    int  base, cyc;
    bit  done;
    model_access(a, wr, d);
    chk("ready_before_req", is_ready, 1);
    base = req_log.size();
    last_base = base;
    addr = a; mem_write = wr; mem_read = !wr; din = d; is_input_valid = 1'b1;
    @(posedge clk);
    #1 is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    cyc = 0; done = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (is_output_valid) begin done = 1; last_dout = dout; last_hit = is_hit; end
    end
    chk("complete", done, 1);
    chk("is_hit", last_hit, exp_hit);
    if (!wr) chk("dout", last_dout, exp_dout);
    if (exp_hit) chk("hit_latency", cyc, 1);
    else chk("miss_latency_ge4", cyc >= 4, 1);
    chk("mem_req_count", req_log.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < req_log.size(); i++) begin
      chk("req_write", req_log[base+i].wr, exp_q[i].wr);
      chk("req_addr", req_log[base+i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk("wb_data", req_log[base+i].data, exp_q[i].data);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] l;
    bit seen;
    int cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_is_ready", is_ready, 1);
    chk("rst_out_valid", is_output_valid, 0);
    chk("rst_is_hit", is_hit, 0);
    chk("rst_dout", dout, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    model_reset();

    // Cold read, then repeat hit.
    do_req(32'h100, 0, 0);
    l = mem_line(32'h10);
    chk("cold_fill_addr", req_log[last_base].addr, 32'h10);
    chk("cold_dout_word0", last_dout, l[31:0]);
    chk("cold_is_hit", last_hit, 0);
    do_req(32'h100, 0, 0);
    chk("warm_is_hit", last_hit, 1);
`ifdef CACHE_STATS_EN
    chk("stat_hits", hit_count, 1);
    chk("stat_misses", miss_count, 1);
`endif

    // Dirty eviction from set 0.
    do_req(32'h104, 1, 32'hDEAD_BEEF);
    do_req(32'h1100, 0, 0);
    do_req(32'h2100, 0, 0);
    chk("evict_wb_write", req_log[last_base].wr, 1);
    chk("evict_wb_addr", req_log[last_base].addr, 32'h10);
    l = req_log[last_base].data;
    chk("evict_wb_word1", l[63:32], 32'hDEAD_BEEF);

    // LRU victim choice after re-reference.
    do_reset();
    do_req(32'h100, 0, 0);
    do_req(32'h1100, 0, 0);
    do_req(32'h100, 0, 0);
    do_req(32'h2100, 0, 0);
    chk("lru_no_wb", req_log.size() - last_base, 1);
    do_req(32'h100, 0, 0);
    chk("lru_kept_100", last_hit, 1);

    // Reset during FILL_WAIT followed by a stale response.
    do_reset();
    stall_mode = 1;
    addr = 32'h100; mem_read = 1'b1; is_input_valid = 1'b1;
    @(posedge clk);
    #1 is_input_valid = 1'b0; mem_read = 1'b0;
    seen = 0; cnt = 0;
    while (!stalled && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (is_output_valid) seen = 1;
    end
    chk("stall_reached", stalled, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", is_ready, 1);
    chk("abort_req_valid", mem_req_valid, 0);
    stale_go = 1;
    repeat (8) begin
      @(negedge clk);
      if (is_output_valid) seen = 1;
    end
    chk("stale_no_completion", seen, 0);
    cnt = 0;
    while (stalled && cnt < 20) begin @(negedge clk); cnt++; end
    stale_go = 0;
    stall_mode = 0;
    model_reset();
    do_req(32'h100, 0, 0);
    chk("post_abort_miss", last_hit, 0);

    // Random traffic concentrated on a few sets and tags to force evictions.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 4) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      do_req(a, $urandom_range(0, 2) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/assoc_wb_cache.md
ASSOC_WB_CACHE -- requirements
Module: assoc_wb_cache

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 16, bytes per line (power of two, >=4).
REQ-002 SHALL have parameter NUM_SETS, default 16, sets (power of two, >=2).
REQ-003 SHALL have parameter NUM_WAYS, default 2, ways per set (power of two, >=1).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port is_input_valid  input  1  CPU request strobe.
REQ-007 SHALL have port addr  input  32  CPU byte address (word-aligned).
REQ-008 SHALL have ports mem_read / mem_write  input  1 each  request type (one-hot when valid).
REQ-009 SHALL have port din  input  32  store data.
REQ-010 SHALL have port is_ready  output  1  cache accepts a request this cycle.
REQ-011 SHALL have port is_output_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port dout  output  32  load data, valid with is_output_valid.
REQ-013 SHALL have port is_hit  output  1  original lookup hit, valid with is_output_valid.
REQ-014 SHALL have ports mem_req_valid, mem_req_write  output  1 each; mem_req_addr  output  32  line address (byte addr >> CLOG2(LINE_SIZE)); mem_req_wdata  output  LINE_SIZE*8.
REQ-015 SHALL have ports mem_ready  input  1; mem_resp_valid  input  1; mem_resp_rdata  input  LINE_SIZE*8.

Function
REQ-016 SHALL split addr into tag | set index (CLOG2(NUM_SETS)) | block offset (CLOG2(LINE_SIZE)); word select = offset[high:2].
REQ-017 SHALL hold per way: valid, dirty, tag, line data; write-back, write-allocate.
REQ-018 SHALL use FSM IDLE, LOOKUP, WRITEBACK, WB_WAIT, FILL, FILL_WAIT; is_ready=1 only in IDLE.
REQ-019 SHALL, in IDLE with is_input_valid, register addr/type/din and go LOOKUP.
REQ-020 SHALL, on LOOKUP hit, pulse is_output_valid that cycle, return IDLE; hit latency is exactly 1 cycle after acceptance.
REQ-021 SHALL, on write hit, merge din into selected word and set dirty at the LOOKUP clock edge.
REQ-022 SHALL, on miss, choose victim: lowest-index invalid way, else LRU way; dirty victim -> WRITEBACK, else -> FILL.
REQ-023 SHALL, in WRITEBACK/FILL, hold mem_req_valid until mem_ready sampled high, then go WB_WAIT / FILL_WAIT.
REQ-024 SHALL, in WB_WAIT, go FILL on mem_resp_valid (write ack); in FILL_WAIT, install line (valid=1, dirty=0, new tag) on mem_resp_valid and go LOOKUP.
REQ-025 SHALL report is_hit=0 for any request that took a miss path, even though the re-LOOKUP hits; miss latency is at least 4 cycles.
REQ-026 SHALL keep true LRU via per-set age counters (CLOG2(NUM_WAYS) bits): accessed way -> 0, ways younger than it +1; update on hit and on fill.
REQ-027 SHALL ignore is_input_valid when is_ready=0; mem_resp_valid outside *_WAIT SHALL be ignored.
REQ-028 SHALL, when NUM_WAYS=1, degenerate to direct-mapped with no LRU state.

Reset
REQ-029 SHALL on reset clear all valid and dirty bits, zero LRU ages, enter IDLE; outputs: is_ready=1, is_output_valid=0, is_hit=0, dout=0, mem_req_valid=0.
REQ-030 SHALL abort any in-flight miss on reset without issuing a completion; a later stale mem_resp_valid SHALL be ignored.

Configuration
REQ-031 SHALL, with CACHE_STATS_EN defined, add outputs hit_count and miss_count (32 bits each), counting completed requests by is_hit, cleared by reset, wrapping at 2^32.
REQ-032 SHALL, without CACHE_STATS_EN, omit those ports and counters entirely.

Structure
REQ-033 SHALL place FSM state encoding and address-field width functions in shared package cache_pkg.
REQ-034 SHALL implement LRU age tracking in one sub-module cache_lru (inputs set, way, update; output victim way).

Verification
REQ-035 SHALL cover: cold read 0x100 -> mem_req_addr 0x10, no writeback, dout = memory word 0, is_hit=0.
REQ-036 SHALL cover: repeated read 0x100 -> is_output_valid 1 cycle after acceptance, is_hit=1, no memory request.
REQ-037 SHALL cover: write 0x104=0xDEADBEEF, then reads 0x1100, 0x2100 (set 0, defaults) -> 0x100 evicted, writeback to line 0x10 with word 1 = 0xDEADBEEF.
REQ-038 SHALL cover: after 0x100, 0x1100, re-read 0x100, read 0x2100 -> victim is 0x1100 (LRU), no writeback.
REQ-039 SHALL cover: reset asserted in FILL_WAIT, then stale mem_resp_valid -> no completion; read 0x100 afterwards misses.
REQ-040 SHALL cover, with CACHE_STATS_EN: scenario 035-036 sequence -> hit_count=1, miss_count=1.
